// File: rtl/cpu7_ifu_fetchq_pkg.sv
// Shared constants for the fetch queue: entry layout and field widths.
// An entry is packed as {pc, inst, ex, exccode}, with exccode in the LSBs.
package cpu7_ifu_fetchq_pkg;

  localparam int FQ_INST_W    = 32;
  localparam int FQ_EXCCODE_W = 6;

  // Field offsets inside a packed entry.
  localparam int FQ_CODE_LSB  = 0;
  localparam int FQ_EX_BIT    = FQ_CODE_LSB + FQ_EXCCODE_W;
  localparam int FQ_INST_LSB  = FQ_EX_BIT + 1;
  localparam int FQ_PC_LSB    = FQ_INST_LSB + FQ_INST_W;

  // Total entry width for a given PC width.
  function automatic int fq_entry_w(input int grlen);
    return grlen + FQ_INST_W + 1 + FQ_EXCCODE_W;
  endfunction

endpackage

// File: rtl/cpu7_ifu_fq_ram.sv
// Fetch-queue storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Entry validity lives in the owner's count/pointers.
module cpu7_ifu_fq_ram #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 71,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the pushed entry into its slot.
  // NOTE: storage has no reset; a slot is only read after being written, so
  // resetting it would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu7_ifu_fetchq.sv
// Fetch front-end queue: sequential fetch PC generation, credit-based
// tracking of outstanding I-mem requests, and a DEPTH-entry queue of
// {pc,inst,exc} feeding decode. Redirects flush the queue and discard
// responses to requests issued before the redirect.
// Optional build macro: CPU7_IFU_FQ_BYPASS_EN -- a kept response arriving at
// an empty queue is presented to decode in the same cycle.
module cpu7_ifu_fetchq
  import cpu7_ifu_fetchq_pkg::*;
#(
  parameter int  GRLEN = 32,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [GRLEN-1:0]        pc_init,
  output logic                    inst_req,
  output logic [GRLEN-1:0]        inst_addr,
  input  logic                    inst_addr_ok,
  output logic                    inst_cancel,
  input  logic                    inst_valid_f,
  input  logic [GRLEN-1:0]        inst_rdata_f,
  input  logic                    inst_ex,
  input  logic [FQ_EXCCODE_W-1:0] inst_exccode,
  input  logic                    redirect_vld,
  input  logic [GRLEN-1:0]        redirect_pc,
  output logic                    fq_dec_vld_d,
  output logic [GRLEN-1:0]        fq_dec_pc_d,
  output logic [FQ_INST_W-1:0]    fq_dec_inst_d,
  output logic                    fq_dec_ex_d,
  output logic [FQ_EXCCODE_W-1:0] fq_dec_exccode_d,
  input  logic                    dec_fq_take,
  output logic [PTR_W:0]          fq_count
);

  localparam int ENTRY_W = fq_entry_w(GRLEN);
  localparam int CW      = PTR_W + 1;

  logic [GRLEN-1:0]   pc_bf_q, pc_bf_d;
  logic [GRLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      drop_q, drop_d;
  logic               halt_q, halt_d;

  logic [CW:0]        credit_sum;
  logic               accept, resp_ret, resp_keep, resp_drop;
  logic               bypass_hit, push, pop, pop_arr;
  logic [ENTRY_W-1:0] resp_entry, rd_entry, head_entry;

  // A request is only issued when a queue slot is guaranteed for its response.
  assign credit_sum  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign inst_req    = ~reset & ~halt_q & ~redirect_vld & (credit_sum < (CW+1)'(DEPTH));
  assign inst_addr   = pc_bf_q;
  assign inst_cancel = redirect_vld & ~reset;
  assign accept      = inst_req & inst_addr_ok;

  // Responses while drop is pending belong to pre-redirect requests.
  assign resp_ret   = inst_valid_f & (outstanding_q != '0);
  assign resp_keep  = inst_valid_f & ~redirect_vld & (drop_q == '0);
  assign resp_drop  = inst_valid_f & ~redirect_vld & (drop_q != '0);
  assign resp_entry = {resp_pc_q, inst_rdata_f[FQ_INST_W-1:0], inst_ex, inst_exccode};

`ifdef CPU7_IFU_FQ_BYPASS_EN
  assign bypass_hit = resp_keep & (count_q == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_entry       = bypass_hit ? resp_entry : rd_entry;
  assign fq_dec_vld_d     = ~reset & ((count_q != '0) | bypass_hit);
  assign fq_dec_pc_d      = head_entry[FQ_PC_LSB +: GRLEN];
  assign fq_dec_inst_d    = head_entry[FQ_INST_LSB +: FQ_INST_W];
  assign fq_dec_ex_d      = head_entry[FQ_EX_BIT];
  assign fq_dec_exccode_d = head_entry[FQ_CODE_LSB +: FQ_EXCCODE_W];
  assign fq_count         = count_q;

  // A bypassed response consumed by decode never touches the array.
  assign pop     = dec_fq_take & fq_dec_vld_d & ~redirect_vld;
  assign push    = resp_keep & ~(bypass_hit & dec_fq_take);
  assign pop_arr = pop & ~bypass_hit;

  cpu7_ifu_fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (resp_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Next-state for PCs, pointers and accounting; redirect overrides everything.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_bf_d       = pc_bf_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halt_d        = halt_q;
    if (redirect_vld) begin
      pc_bf_d       = redirect_pc;
      resp_pc_d     = redirect_pc;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      halt_d        = 1'b0;
      // Everything still in flight is stale; a response arriving now is too.
      outstanding_d = outstanding_q - CW'(resp_ret);
      drop_d        = outstanding_q - CW'(resp_ret);
    end else begin
      if (accept) pc_bf_d = pc_bf_q + GRLEN'(4);
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_ret);
      if (resp_drop) drop_d = drop_q - CW'(1);
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + GRLEN'(4);
        if (inst_ex) halt_d = 1'b1;
      end
      if (push)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_arr) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CW'(push) - CW'(pop_arr);
    end
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_bf_q       <= pc_init;
      resp_pc_q     <= pc_init;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      halt_q        <= 1'b0;
    end else begin
      pc_bf_q       <= pc_bf_d;
      resp_pc_q     <= resp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halt_q        <= halt_d;
    end
  end

endmodule
